// File: rtl/posit_pkg.sv
// Shared operation, opgroup and status definitions for the posit issue path.
// Also provides the opcode-to-opgroup mapping used for dispatch steering.
package posit_pkg;

    localparam int OP_BITS      = 4;
    localparam int NUM_OPGROUPS = 4;

    typedef enum logic [OP_BITS-1:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CMP      = 4'd8,
        CLASSIFY = 4'd9,
        F2F      = 4'd10,
        F2I      = 4'd11,
        I2F      = 4'd12,
        CPKAB    = 4'd13,
        CPKCD    = 4'd14
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        ROD = 3'd5,
        DYN = 3'd7
    } roundmode_e;

    typedef enum logic [1:0] {
        ADDMUL  = 2'd0,
        DIVSQRT = 2'd1,
        NONCOMP = 2'd2,
        CONV    = 2'd3
    } opgroup_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    // Element i of the mask belongs to opgroup i.
    typedef logic [0:NUM_OPGROUPS-1] opgrp_logic_t;

    function automatic opgroup_e get_opgroup(operation_e op);
        case (op)
            FMADD, FNMSUB, ADD, MUL:       return ADDMUL;
            DIV, SQRT:                     return DIVSQRT;
            SGNJ, MINMAX, CMP, CLASSIFY:   return NONCOMP;
            F2F, F2I, I2F, CPKAB, CPKCD:   return CONV;
            default:                       return NONCOMP;
        endcase
    endfunction

endpackage

// File: rtl/posit_rr_arbiter.sv
// Round-robin single-grant arbiter; the search starts at an internal pointer that
// moves to one past the granted requester whenever advance_i is high.
module posit_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                if (advance_i) begin
                    ptr_d = PTR_W'((idx + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/posit_issue_ctrl.sv
// Issue controller: steers operations to opgroup units with per-group credit
// limits and merges their results through a round-robin arbitrated output register.
// Optional flush port enabled by defining POSIT_ISSUE_FLUSH_EN.
module posit_issue_ctrl import posit_pkg::*; #(
    parameter int NUM_GRP = NUM_OPGROUPS,
    parameter int TAG_W   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef POSIT_ISSUE_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [OP_BITS-1:0]    op_i,
    input  logic [2:0]            rnd_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic [NUM_GRP-1:0]    grp_valid_o,
    input  logic [NUM_GRP-1:0]    grp_ready_i,
    output logic [OP_BITS-1:0]    grp_op_o,
    output logic [2:0]            grp_rnd_o,
    output logic [TAG_W-1:0]      grp_tag_o,
    input  logic [NUM_GRP-1:0]    res_valid_i,
    output logic [NUM_GRP-1:0]    res_ready_o,
    input  logic [NUM_GRP*32-1:0] res_data_i,
    input  logic [NUM_GRP*5-1:0]  res_status_i,
    input  logic [NUM_GRP*TAG_W-1:0] res_tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_data_o,
    output logic [4:0]            out_status_o,
    output logic [TAG_W-1:0]      out_tag_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt_q [NUM_GRP];
    logic [CNT_W-1:0] cnt_d [NUM_GRP];
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    status_t          out_status_q, out_status_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    opgrp_logic_t     tgt_mask;
    logic [NUM_GRP-1:0] tgt_vec, room, grant, res_acc;
    logic             out_free, dispatch, flush_act, any_cnt;
    logic [31:0]      sel_data;
    status_t          sel_status;
    logic [TAG_W-1:0] sel_tag;

`ifdef POSIT_ISSUE_FLUSH_EN
    assign flush_act = flush_i;
`else
    assign flush_act = 1'b0;
`endif

    always_comb begin
        tgt_mask = '0;
        tgt_mask[get_opgroup(operation_e'(op_i))] = 1'b1;
    end

    // Groups beyond the package's opgroup set never receive operations.
    for (genvar g = 0; g < NUM_GRP; g++) begin : g_tgt
        if (g < NUM_OPGROUPS) begin : g_map
            assign tgt_vec[g] = tgt_mask[g];
        end else begin : g_none
            assign tgt_vec[g] = 1'b0;
        end
        assign room[g] = (cnt_q[g] < CNT_W'(MAX_OUT));
    end

    assign in_ready_o  = (|(tgt_vec & room & grp_ready_i)) & ~flush_act;
    assign grp_valid_o = (in_valid_i & ~flush_act) ? (tgt_vec & room) : '0;
    assign dispatch    = in_valid_i & in_ready_o;
    assign grp_op_o    = op_i;
    assign grp_rnd_o   = rnd_i;
    assign grp_tag_o   = tag_i;

    assign out_free = ~out_valid_q | out_ready_i;

    posit_rr_arbiter #(
        .NUM_REQ (NUM_GRP)
    ) u_rr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (res_valid_i),
        .advance_i (out_free & ~flush_act),
        .grant_o   (grant)
    );

    assign res_ready_o = flush_act ? '1 : (out_free ? grant : '0);
    assign res_acc     = flush_act ? '0 : (res_valid_i & res_ready_o);

    always_comb begin
        sel_data   = '0;
        sel_status = '0;
        sel_tag    = '0;
        for (int k = 0; k < NUM_GRP; k++) begin
            if (grant[k]) begin
                sel_data   = res_data_i[k*32 +: 32];
                sel_status = status_t'(res_status_i[k*5 +: 5]);
                sel_tag    = res_tag_i[k*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        any_cnt = 1'b0;
        for (int g = 0; g < NUM_GRP; g++) begin
            cnt_d[g] = cnt_q[g];
            if (flush_act) begin
                cnt_d[g] = '0;
            end else if ((dispatch & tgt_vec[g]) && !res_acc[g]) begin
                cnt_d[g] = cnt_q[g] + CNT_W'(1);
            end else if (!(dispatch & tgt_vec[g]) && res_acc[g] && (cnt_q[g] != '0)) begin
                cnt_d[g] = cnt_q[g] - CNT_W'(1);
            end
            if (cnt_q[g] != '0) begin
                any_cnt = 1'b1;
            end
        end
    end

    // A pop and a new load in the same cycle keep the register full (no bubble).
    always_comb begin
        out_valid_d  = out_valid_q & ~out_ready_i;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        out_tag_d    = out_tag_q;
        if (flush_act) begin
            out_valid_d = 1'b0;
        end else if (|res_acc) begin
            out_valid_d  = 1'b1;
            out_data_d   = sel_data;
            out_status_d = sel_status;
            out_tag_d    = sel_tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                cnt_q[g] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= '0;
            out_tag_q    <= '0;
        end else begin
            for (int g = 0; g < NUM_GRP; g++) begin
                cnt_q[g] <= cnt_d[g];
            end
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_status_o = out_status_q;
    assign out_tag_o    = out_tag_q;
    assign busy_o       = any_cnt | out_valid_q;

endmodule

// File: tb/tb_posit_issue_ctrl.sv
// Self-checking bench for posit_issue_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue-level model.
module tb_posit_issue_ctrl;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int MO = 4;

    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_F2I = 4'd11;

    logic clk = 1'b0;
    logic rst_i;
    logic flush_s;
    logic in_valid_i, in_ready_o;
    logic [3:0] op_i;
    logic [2:0] rnd_i;
    logic [TW-1:0] tag_i;
    logic [N-1:0] grp_valid_o, grp_ready_i;
    logic [3:0] grp_op_o;
    logic [2:0] grp_rnd_o;
    logic [TW-1:0] grp_tag_o;
    logic [N-1:0] res_valid_i, res_ready_o;
    logic [N*32-1:0] res_data_i;
    logic [N*5-1:0] res_status_i;
    logic [N*TW-1:0] res_tag_i;
    logic out_valid_o, out_ready_i;
    logic [31:0] out_data_o;
    logic [4:0] out_status_o;
    logic [TW-1:0] out_tag_o;
    logic busy_o;

    always #5 clk = ~clk;

    posit_issue_ctrl #(.NUM_GRP(N), .TAG_W(TW), .MAX_OUT(MO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
`ifdef POSIT_ISSUE_FLUSH_EN
        .flush_i      (flush_s),
`endif
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .op_i         (op_i),
        .rnd_i        (rnd_i),
        .tag_i        (tag_i),
        .grp_valid_o  (grp_valid_o),
        .grp_ready_i  (grp_ready_i),
        .grp_op_o     (grp_op_o),
        .grp_rnd_o    (grp_rnd_o),
        .grp_tag_o    (grp_tag_o),
        .res_valid_i  (res_valid_i),
        .res_ready_o  (res_ready_o),
        .res_data_i   (res_data_i),
        .res_status_i (res_status_i),
        .res_tag_i    (res_tag_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_status_o (out_status_o),
        .out_tag_o    (out_tag_o),
        .busy_o       (busy_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: outstanding count per group, round-robin start, output slot.
    int          m_cnt [N];
    int          m_ptr;
    bit          m_ov;
    logic [31:0] m_data;
    logic [4:0]  m_st;
    logic [TW-1:0] m_tag;

    int          e_g, e_k;
    logic [N-1:0] e_gv, e_rr;
    logic        e_ir, e_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic int grp_of(input logic [3:0] op);
        if (op <= 4'd3) return 0;
        if (op <= 4'd5) return 1;
        if (op <= 4'd9) return 2;
        if (op <= 4'd14) return 3;
        return 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0; m_ov = 0; m_data = '0; m_st = '0; m_tag = '0;
    endtask

    task automatic drive_idle();
        in_valid_i = 0; op_i = '0; rnd_i = '0; tag_i = '0; grp_ready_i = '0;
        res_valid_i = '0; res_data_i = '0; res_status_i = '0; res_tag_i = '0;
        out_ready_i = 1; flush_s = 0;
    endtask

    task automatic settle();
        #1;
        e_g  = grp_of(op_i);
        e_gv = '0;
        e_ir = 1'b0;
        if (!flush_s && m_cnt[e_g] < MO) begin
            e_gv[e_g] = in_valid_i;
            e_ir      = grp_ready_i[e_g];
        end
        e_k = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (e_k < 0 && res_valid_i[k]) e_k = k;
        end
        e_rr = '0;
        if (flush_s) e_rr = '1;
        else if (e_k >= 0 && (!m_ov || out_ready_i)) e_rr[e_k] = 1'b1;
        e_busy = m_ov;
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) e_busy = 1'b1;
        chk("grp_valid", grp_valid_o, e_gv);
        chk("in_ready", in_ready_o, e_ir);
        chk("grp_fields", {grp_op_o, grp_rnd_o, grp_tag_o}, {op_i, rnd_i, tag_i});
        chk("res_ready", res_ready_o, e_rr);
        chk("out_valid", out_valid_o, m_ov);
        chk("out_data", out_data_o, m_data);
        chk("out_status_tag", {out_status_o, out_tag_o}, {m_st, m_tag});
        chk("busy", busy_o, e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush_s) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ov = 0;
        end else begin
            if (in_valid_i && e_ir) m_cnt[e_g]++;
            if (m_ov && out_ready_i) m_ov = 0;
            if (e_rr != '0) begin
                if (m_cnt[e_k] > 0) m_cnt[e_k]--;
                m_ov   = 1;
                m_data = res_data_i[e_k*32 +: 32];
                m_st   = res_status_i[e_k*5 +: 5];
                m_tag  = res_tag_i[e_k*TW +: TW];
                m_ptr  = (e_k + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rv;
        rst_i = 1;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_out_regs", {out_data_o, out_status_o, out_tag_o}, 0);
        rst_i = 0;

        // Single ADD: zero-latency dispatch, result out one cycle after acceptance.
        in_valid_i = 1; op_i = OP_ADD; tag_i = 4'd3; grp_ready_i = 4'b0001;
        settle();
        chk("add_grp_valid", grp_valid_o, 4'b0001);
        chk("add_in_ready", in_ready_o, 1);
        tick();
        drive_idle();
        res_valid_i = 4'b0001; res_data_i[31:0] = 32'h4000_0000; res_tag_i[3:0] = 4'd3;
        settle();
        chk("add_res_ready", res_ready_o, 4'b0001);
        chk("add_no_early_out", out_valid_o, 0);
        tick();
        drive_idle();
        settle();
        chk("add_out_valid", out_valid_o, 1);
        chk("add_out_data", out_data_o, 32'h4000_0000);
        chk("add_out_tag", out_tag_o, 4'd3);
        tick();

        // Five DIVs against a credit of four.
        drive_idle();
        grp_ready_i = 4'hF; op_i = OP_DIV; in_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            tag_i = TW'(i);
            settle();
            chk("div_credit", in_ready_o, (i < 4) ? 1 : 0);
            tick();
        end
        res_valid_i = 4'b0010; res_data_i[63:32] = 32'h0000_00D1;
        settle();
        chk("div_full", in_ready_o, 0);
        chk("div_res_ready", res_ready_o, 4'b0010);
        tick();
        res_valid_i = '0;
        settle();
        chk("div_reopen", in_ready_o, 1);
        tick();
        in_valid_i = 0; res_valid_i = 4'b0010;
        repeat (4) begin settle(); tick(); end
        res_valid_i = '0;
        settle(); tick();
        settle();
        chk("div_idle_busy", busy_o, 0);
        tick();

        // Reset in the middle of activity: two ADDs in flight, one result held.
        drive_idle();
        out_ready_i = 0; grp_ready_i = 4'hF; op_i = OP_ADD; in_valid_i = 1;
        repeat (3) begin settle(); tick(); end
        in_valid_i = 0; res_valid_i = 4'b0001; res_data_i[31:0] = 32'h0000_ABCD;
        settle(); tick();
        res_valid_i = '0;
        settle();
        chk("pre_rst_out_valid", out_valid_o, 1);
        chk("pre_rst_busy", busy_o, 1);
        rst_i = 1;
        #1;
        chk("mid_rst_out_valid", out_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_out_data", out_data_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_i = 0;
        drive_idle();

        // Two ops into every group, then all results valid continuously.
        grp_ready_i = 4'hF; in_valid_i = 1;
        for (int g = 0; g < N; g++) begin
            case (g)
                0: op_i = OP_ADD;
                1: op_i = OP_DIV;
                2: op_i = OP_CMP;
                default: op_i = OP_F2I;
            endcase
            repeat (2) begin settle(); tick(); end
        end
        in_valid_i = 0;
        res_valid_i = 4'hF;
        res_data_i = {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rr_order", res_ready_o, 4'b0001 << (i % 4));
            if (i > 0) chk("rr_no_bubble", out_valid_o, 1);
            tick();
        end

        // Output stall with results pending, then release.
        res_valid_i = 4'b1110; out_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_res_ready", res_ready_o, 0);
            chk("stall_out_data", out_data_o, 32'h0000_00C0);
            chk("stall_out_valid", out_valid_o, 1);
            tick();
        end
        out_ready_i = 1;
        settle();
        chk("release_grant", res_ready_o, 4'b0010);
        tick();
        res_valid_i = '0;
        settle();
        chk("release_data", out_data_o, 32'h0000_00C1);
        tick();

`ifdef POSIT_ISSUE_FLUSH_EN
        drive_idle();
        grp_ready_i = 4'hF; in_valid_i = 1;
        op_i = OP_ADD; settle(); tick();
        op_i = OP_DIV; settle(); tick();
        op_i = OP_CMP; settle(); tick();
        in_valid_i = 0; flush_s = 1; res_valid_i = 4'b0111;
        settle();
        chk("flush_in_ready", in_ready_o, 0);
        chk("flush_res_ready", res_ready_o, 4'hF);
        tick();
        flush_s = 0; res_valid_i = '0;
        settle();
        chk("flush_busy", busy_o, 0);
        chk("flush_out_valid", out_valid_o, 0);
        tick();
`endif

        // Randomized traffic; results only come from groups with work outstanding.
        drive_idle();
        for (int c = 0; c < 3000; c++) begin
            in_valid_i   = 1'($urandom_range(0, 1));
            op_i         = 4'($urandom_range(0, 15));
            rnd_i        = 3'($urandom);
            tag_i        = TW'($urandom);
            grp_ready_i  = N'($urandom);
            out_ready_i  = ($urandom_range(0, 3) != 0);
            rv = '0;
            for (int k = 0; k < N; k++) if (m_cnt[k] > 0 && $urandom_range(0, 1) == 1) rv[k] = 1'b1;
            res_valid_i  = rv;
            res_data_i   = {$urandom, $urandom, $urandom, $urandom};
            res_status_i = (N*5)'($urandom);
            res_tag_i    = (N*TW)'($urandom);
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/posit_issue_ctrl.md
POSIT_ISSUE_CTRL -- requirements
Module: posit_issue_ctrl

Interface
REQ-001 Parameter NUM_GRP, default 4 (NUM_OPGROUPS), number of opgroup units served.
REQ-002 Parameter TAG_W, default 4, width of the operation tag.
REQ-003 Parameter MAX_OUT, default 4, max in-flight operations per opgroup.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 in_valid_i / in_ready_o  in/out  1/1  issue handshake.
REQ-007 op_i  in  OP_BITS  operation_e; rnd_i  in  3  roundmode_e; tag_i  in  TAG_W.
REQ-008 grp_valid_o / grp_ready_i  out/in  NUM_GRP / NUM_GRP  per-opgroup dispatch handshake.
REQ-009 grp_op_o, grp_rnd_o, grp_tag_o  out  OP_BITS, 3, TAG_W  fields broadcast to all opgroups.
REQ-010 res_valid_i / res_ready_o  in/out  NUM_GRP / NUM_GRP  per-opgroup result handshake.
REQ-011 res_data_i, res_status_i, res_tag_i  in  NUM_GRP x 32, 5 (status_t), TAG_W.
REQ-012 out_valid_o / out_ready_i  out/in  1/1; out_data_o 32, out_status_o 5, out_tag_o TAG_W, all out.
REQ-013 busy_o  out  1  any operation in flight or held in the output register.

Function
REQ-014 Target group g = get_opgroup(op_i); unlisted op codes map to NONCOMP.
REQ-015 grp_valid_o[g] = in_valid_i & (cnt[g] < MAX_OUT); other grp_valid_o bits 0; dispatch is combinational, zero latency.
REQ-016 in_ready_o = grp_ready_i[g] & (cnt[g] < MAX_OUT); a dispatch occurs when in_valid_i & in_ready_o.
REQ-017 Per-group counter cnt[g]: +1 on dispatch to g, -1 on result accept from g; both in the same cycle leave it unchanged; never exceeds MAX_OUT, never wraps below 0.
REQ-018 Result arbitration is round-robin over res_valid_i, starting at rr_ptr; after a grant to group k, rr_ptr becomes (k+1) mod NUM_GRP.
REQ-019 res_ready_o[k] = grant[k] & (~out_valid_o | out_ready_i); at most one bit is set per cycle.
REQ-020 The accepted result is stored in a one-entry output register; out_valid_o rises the cycle after acceptance (1-cycle latency).
REQ-021 The output register holds data, status and tag stable while out_valid_o & ~out_ready_i.
REQ-022 With out_valid_o & out_ready_i and a new grant in the same cycle, the register reloads without a bubble, sustaining 1 result/cycle.
REQ-023 busy_o = (|cnt) | out_valid_o.

Reset
REQ-024 While rst_i is high: every cnt = 0, rr_ptr = 0, out_valid_o = 0, out_data_o = 0, out_status_o = 0, out_tag_o = 0.
REQ-025 A reset asserted mid-operation discards all in-flight bookkeeping and the held result, with no output handshake.

Configuration
REQ-026 Macro POSIT_ISSUE_FLUSH_EN defined: port flush_i (in, 1) exists. While it is high: in_ready_o = 0, all res_ready_o = 1 with results discarded, out_valid_o cleared next cycle, and all cnt cleared next cycle.
REQ-027 Macro undefined: no flush_i port and no flush logic.

Structure
REQ-028 operation_e, opgroup_e, status_t, OP_BITS, NUM_OPGROUPS and get_opgroup come from posit_pkg.
REQ-029 A new package typedef opgrp_logic_t (logic [0:NUM_OPGROUPS-1]) is added and used for per-group masks.
REQ-030 The round-robin grant logic is a sub-module named posit_rr_arbiter, with a NUM_REQ parameter and req/grant/advance ports.

Verification
REQ-031 Issue op=ADD, tag=3; ADDMUL unit ready -> grp_valid_o=4'b0001 in the same cycle; result returned with data 32'h4000_0000 -> out_valid_o one cycle later, out_tag_o=3.
REQ-032 Issue 5 DIV ops with grp_ready_i held at 1 and no results -> the first 4 dispatch, then in_ready_o=0; one DIV result accepted -> in_ready_o=1 again.
REQ-033 res_valid_i=4'b1111 every cycle, out_ready_i=1 -> grants in order 0,1,2,3,0 with no idle cycles.
REQ-034 out_ready_i=0 for 3 cycles with a pending result -> outputs stable, res_ready_o=0; on release, next grant accepted the same cycle.
REQ-035 rst_i pulsed while cnt[ADDMUL]=2 and out_valid_o=1 -> out_valid_o=0, busy_o=0 immediately.
REQ-036 With POSIT_ISSUE_FLUSH_EN defined, flush_i for 1 cycle with 3 ops in flight -> busy_o=0 the next cycle, late results are drained without out_valid_o.
